sum_stream: RTL and testbench

SUM_STREAM -- requirements
Module: sum_stream

---
 rtl/sum_stream_pkg.sv | 29 ++
 rtl/sum_stream_sat_add.sv | 25 ++
 rtl/sum_stream.sv | 132 +++++++++++++
 tb/tb_sum_stream.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sum_stream_pkg.sv
// sum_stream_pkg
//   Shared types for the sum_stream block: FSM state encoding and the
//   latched operation mode encoding.
package sum_stream_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Mode 2'b11 is folded into ADD when latched, so it never appears here.
   typedef enum logic [1:0] {
      ADD   = 2'b00,
      MAX   = 2'b01,
      COUNT = 2'b10
   } mode_t;

   function automatic mode_t decode_mode(input logic [1:0] m);
      mode_t d;
      case (m)
         2'b01:   d = MAX;
         2'b10:   d = COUNT;
         default: d = ADD;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/sum_stream_sat_add.sv
// sat_add
//   Unsigned saturating adder. The sum clamps to all-ones when the true
//   result does not fit in W bits; ovf flags that this happened.
// Ports:
//   a, b  : W-bit unsigned operands
//   sum   : saturated W-bit sum
//   ovf   : 1 when the unsaturated sum exceeded 2^W-1
module sat_add #(
   parameter int unsigned W = 12
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W:0] full;

   always_comb begin
      full = {1'b0, a} + {1'b0, b};
      ovf  = full[W];
      sum  = full[W] ? '1 : full[W-1:0];
   end

endmodule

// File: rtl/sum_stream.sv
// sum_stream
//   Consumes a stream of unsigned samples after a start request and reduces
//   them (saturating sum, maximum, or sample count) until a terminator value
//   arrives or MAX_TERMS samples have been taken, then pulses done.
// Ports:
//   ck     : clock, rising edge
//   reset  : asynchronous active-high reset
//   go_l   : active-low start, honoured only in IDLE
//   mode   : 00 ADD, 01 MAX, 10 COUNT, 11 ADD; latched at start
//   inA    : sample stream, one per cycle while running
//   done   : one-cycle pulse when result/count/ovf/trunc are final
//   result : reduced value, held until the next start
//   count  : number of non-terminator samples consumed
//   ovf    : sticky saturation flag for the current run (ADD)
//   trunc  : run ended by hitting MAX_TERMS rather than the terminator
module sum_stream
   import sum_stream_pkg::*;
#(
   parameter  int unsigned      WIDTH     = 8,
   parameter  int unsigned      ACC_W     = 12,
   parameter  int unsigned      MAX_TERMS = 15,
   parameter  logic [WIDTH-1:0] TERM      = '0,
   localparam int unsigned      CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic             ck,
   input  logic             reset,
   input  logic             go_l,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] inA,
   output logic             done,
   output logic [ACC_W-1:0] result,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   output logic             trunc
);

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [ACC_W-1:0] result_d;
   logic [CNT_W-1:0] count_d;
   logic             ovf_d, trunc_d, done_d;

   logic [ACC_W-1:0] sample_ext;
   logic [CNT_W-1:0] count_inc;
   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;

   assign sample_ext = ACC_W'(inA);
   assign count_inc  = count + CNT_W'(1);

   sat_add #(.W(ACC_W)) u_sat_add (
      .a   (result),
      .b   (sample_ext),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         mode_q  <= ADD;
         result  <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         trunc   <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         result  <= result_d;
         count   <= count_d;
         ovf     <= ovf_d;
         trunc   <= trunc_d;
         done    <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      result_d = result;
      count_d  = count;
      ovf_d    = ovf;
      trunc_d  = trunc;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (!go_l) begin
               state_d  = RUN;
               mode_d   = decode_mode(mode);
               result_d = '0;
               count_d  = '0;
               ovf_d    = 1'b0;
               trunc_d  = 1'b0;
            end
         end

         RUN: begin
            if (inA == TERM) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               count_d = count_inc;
               case (mode_q)
                  MAX:     result_d = (sample_ext > result) ? sample_ext : result;
                  COUNT:   result_d = ACC_W'(count_inc);
                  default: begin
                     result_d = add_sum;
                     ovf_d    = ovf | add_ovf;
                  end
               endcase
               // The sample that reaches the limit is still accumulated.
               if (count_inc == CNT_W'(MAX_TERMS)) begin
                  trunc_d = 1'b1;
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sum_stream.sv
module tb_sum_stream;

   logic ck = 1'b0;
   always #5 ck = ~ck;

   logic       reset;
   logic       go_l_a, go_l_b;
   logic [1:0] mode_a, mode_b;
   logic [7:0] in_a, in_b;
   logic       done_a, done_b;
   logic [11:0] res_a, res_b;
   logic [3:0] cnt_a;
   logic [4:0] cnt_b;
   logic       ovf_a, ovf_b, tr_a, tr_b;

   // Default configuration.
   sum_stream dut_a (
      .ck     (ck),
      .reset  (reset),
      .go_l   (go_l_a),
      .mode   (mode_a),
      .inA    (in_a),
      .done   (done_a),
      .result (res_a),
      .count  (cnt_a),
      .ovf    (ovf_a),
      .trunc  (tr_a)
   );

   // Longer run limit so saturation is reachable without truncation.
   sum_stream #(.MAX_TERMS(20)) dut_b (
      .ck     (ck),
      .reset  (reset),
      .go_l   (go_l_b),
      .mode   (mode_b),
      .inA    (in_b),
      .done   (done_b),
      .result (res_b),
      .count  (cnt_b),
      .ovf    (ovf_b),
      .trunc  (tr_b)
   );

   typedef struct {
      int res;
      int cnt;
      int ovf;
      int tr;
      int cyc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   logic [7:0] vec[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge ck) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge ck);
      #1;
   endtask

   task automatic drive(input bit sel, input logic g, input logic [1:0] m, input logic [7:0] d);
      if (sel) begin
         go_l_b = g; mode_b = m; in_b = d;
      end else begin
         go_l_a = g; mode_a = m; in_a = d;
      end
   endtask

   // Start a run, feed vec (last element ends the run), record the expected
   // result for the monitor, then step through the DONE cycle.
   task automatic run(input bit sel, input logic [1:0] m, input logic g_run,
                      input int er, input int ec, input int eo, input int et);
      exp_t e;
      drive(sel, 1'b0, m, 8'hA5);
      step(1);
      if (sel) chk("b_start_clear", {res_b, cnt_b, ovf_b, tr_b}, 0);
      else     chk("a_start_clear", {res_a, cnt_a, ovf_a, tr_a}, 0);
      foreach (vec[i]) begin
         drive(sel, g_run, m, vec[i]);
         step(1);
      end
      e = '{er, ec, eo, et, cyc};
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
      drive(sel, g_run, m, 8'h3C);
      step(1);
      drive(sel, 1'b1, m, 8'h5A);
   endtask

   always @(negedge ck) begin
      exp_t e;
      if (done_a === 1'b1) begin
         if (q_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_done: got done=1 expected done=0");
         end else begin
            e = q_a.pop_front();
            chk("a_result", res_a, e.res);
            chk("a_count",  cnt_a, e.cnt);
            chk("a_ovf",    ovf_a, e.ovf);
            chk("a_trunc",  tr_a,  e.tr);
            chk("a_done_cycle", cyc, e.cyc);
         end
      end
   end

   always @(negedge ck) begin
      exp_t e;
      if (done_b === 1'b1) begin
         if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_done: got done=1 expected done=0");
         end else begin
            e = q_b.pop_front();
            chk("b_result", res_b, e.res);
            chk("b_count",  cnt_b, e.cnt);
            chk("b_ovf",    ovf_b, e.ovf);
            chk("b_trunc",  tr_b,  e.tr);
            chk("b_done_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b1, 2'b00, 8'h00);
      drive(1'b1, 1'b1, 2'b00, 8'h00);
      step(2);
      chk("a_reset_state", {done_a, res_a, cnt_a, ovf_a, tr_a}, 0);
      chk("b_reset_state", {done_b, res_b, cnt_b, ovf_b, tr_b}, 0);
      reset = 1'b0;
      step(1);

      // ADD: 3+5+7
      vec = '{8'd3, 8'd5, 8'd7, 8'd0};
      run(1'b0, 2'b00, 1'b1, 15, 3, 0, 0);
      drive(1'b0, 1'b1, 2'b01, 8'h55);
      step(3);
      chk("a_idle_hold_result", res_a, 15);
      chk("a_idle_hold_count", cnt_a, 3);

      // MAX and COUNT on the same stream
      vec = '{8'd9, 8'd200, 8'd4, 8'd0};
      run(1'b0, 2'b01, 1'b1, 200, 3, 0, 0);
      run(1'b0, 2'b10, 1'b1, 3, 3, 0, 0);

      // Mode 11 acts as ADD; go_l low during RUN/DONE is ignored
      vec = '{8'd10, 8'd20, 8'd0};
      run(1'b0, 2'b11, 1'b0, 30, 2, 0, 0);

      // Truncation: 15 ones, no terminator
      vec.delete();
      for (int i = 0; i < 15; i++) vec.push_back(8'd1);
      run(1'b0, 2'b00, 1'b1, 15, 15, 0, 1);

      // Immediate terminator, back-to-back with go_l held low
      vec = '{8'd0};
      run(1'b0, 2'b00, 1'b0, 0, 0, 0, 0);
      run(1'b0, 2'b00, 1'b0, 0, 0, 0, 0);
      step(2);

      // Reset in the middle of a run
      drive(1'b0, 1'b0, 2'b00, 8'hA5);
      step(1);
      drive(1'b0, 1'b1, 2'b00, 8'd2);
      step(2);
      chk("a_midrun_result", res_a, 4);
      reset = 1'b1;
      #1;
      chk("a_async_reset_clear", {done_a, res_a, cnt_a, ovf_a, tr_a}, 0);
      step(1);
      reset = 1'b0;
      step(1);
      vec = '{8'd4, 8'd0};
      run(1'b0, 2'b00, 1'b1, 4, 1, 0, 0);

      // Saturation on the MAX_TERMS=20 instance
      drive(1'b1, 1'b0, 2'b00, 8'hA5);
      step(1);
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 2'b00, 8'd255);
         step(1);
      end
      chk("b_res_16", res_b, 4080);
      chk("b_ovf_16", ovf_b, 0);
      drive(1'b1, 1'b1, 2'b00, 8'd255);
      step(1);
      chk("b_res_17", res_b, 4095);
      chk("b_ovf_17", ovf_b, 1);
      drive(1'b1, 1'b1, 2'b00, 8'd1);
      step(1);
      chk("b_res_18", res_b, 4095);
      chk("b_ovf_sticky", ovf_b, 1);
      chk("b_count_18", cnt_b, 18);
      drive(1'b1, 1'b1, 2'b00, 8'd0);
      step(1);
      q_b.push_back('{4095, 18, 1, 0, cyc});
      drive(1'b1, 1'b1, 2'b00, 8'h3C);
      step(3);

      chk("a_pending_results", q_a.size(), 0);
      chk("b_pending_results", q_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
